// File: rtl/dwell_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dwell_pkg
// Brief    : Shared state encoding and parameter sanity helpers for the dwell conditioner.
// Revision : 1.0
// ============================================================================
package dwell_pkg;

    typedef enum logic [2:0] {
        OFF_HOLD  = 3'd0,
        OFF_READY = 3'd1,
        ON_HOLD   = 3'd2,
        ON_READY  = 3'd3,
        LOCKOUT   = 3'd4
    } dwell_state_t;

    // True when a tick count is at least 1 and representable in a WIDTH-bit counter.
    function automatic bit dwell_fits(input int value, input int width);
        return (value >= 1) && (longint'(value) <= ((longint'(1) << width) - 1));
    endfunction

    function automatic bit dwell_max_ok(input int max_on, input int min_on);
        return max_on > min_on;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Brief    : Saturating dwell counter with synchronous clear and tick enable.
// Revision : 1.0
// ============================================================================
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clk_enable,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clk_enable) begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (r_cnt != {WIDTH{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/output_dwell_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : output_dwell_conditioner
// Brief    : Enforces minimum on/off dwell on an actuator drive; DWELL_MAX_ON_EN adds max-on lockout.
// Revision : 1.0
// ============================================================================
module output_dwell_conditioner
    import dwell_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_ON  = 4,
    parameter int MIN_OFF = 4,
    parameter int MAX_ON  = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic request,
    output logic drive,
    output logic holding,
    output logic fault
);

    if (!dwell_fits(MIN_ON, WIDTH)) begin : g_bad_min_on
        $error("MIN_ON must be in 1..2^WIDTH-1");
    end
    if (!dwell_fits(MIN_OFF, WIDTH)) begin : g_bad_min_off
        $error("MIN_OFF must be in 1..2^WIDTH-1");
    end
    if (!dwell_max_ok(MAX_ON, MIN_ON)) begin : g_bad_max_on
        $error("MAX_ON must exceed MIN_ON");
    end

    localparam logic [WIDTH-1:0] c_min_on_last  = WIDTH'(MIN_ON - 1);
    localparam logic [WIDTH-1:0] c_min_off_last = WIDTH'(MIN_OFF - 1);

    dwell_state_t     r_state;
    dwell_state_t     w_state_next;
    logic             r_drive;
    logic             w_drive_next;
    logic             w_clear;
    logic [WIDTH-1:0] w_cnt;
    logic             w_min_on_met;
    logic             w_min_off_met;

    // Counter restarts on every entry into a hold or lockout state.
    dwell_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_clk_enable (clk_enable),
        .i_clear      (w_clear),
        .o_cnt        (w_cnt)
    );

    assign w_min_on_met  = (w_cnt >= c_min_on_last);
    assign w_min_off_met = (w_cnt >= c_min_off_last);

`ifdef DWELL_MAX_ON_EN
    if (!dwell_fits(MAX_ON, WIDTH)) begin : g_bad_max_on_width
        $error("MAX_ON must fit in WIDTH bits when max-on lockout is enabled");
    end

    localparam logic [WIDTH-1:0] c_max_on_last = WIDTH'(MAX_ON - 1);

    logic r_fault;
    logic w_fault_next;
    logic w_max_on_hit;

    assign w_max_on_hit = (w_cnt >= c_max_on_last);
`endif

    always_comb begin
        w_state_next = r_state;
        w_drive_next = r_drive;
        w_clear      = 1'b0;
`ifdef DWELL_MAX_ON_EN
        w_fault_next = r_fault;
`endif
        case (r_state)
            OFF_READY: begin
                if (request) begin
                    w_state_next = ON_HOLD;
                    w_drive_next = 1'b1;
                    w_clear      = 1'b1;
                end
            end
            ON_HOLD: begin
`ifdef DWELL_MAX_ON_EN
                if (request && w_max_on_hit) begin
                    w_state_next = LOCKOUT;
                    w_drive_next = 1'b0;
                    w_fault_next = 1'b1;
                    w_clear      = 1'b1;
                end else
`endif
                if (w_min_on_met) begin
                    if (request) begin
                        w_state_next = ON_READY;
                    end else begin
                        w_state_next = OFF_HOLD;
                        w_drive_next = 1'b0;
                        w_clear      = 1'b1;
                    end
                end
            end
            ON_READY: begin
                // A release on the same tick as max-on expiry takes the normal off path.
                if (!request) begin
                    w_state_next = OFF_HOLD;
                    w_drive_next = 1'b0;
                    w_clear      = 1'b1;
                end
`ifdef DWELL_MAX_ON_EN
                else if (w_max_on_hit) begin
                    w_state_next = LOCKOUT;
                    w_drive_next = 1'b0;
                    w_fault_next = 1'b1;
                    w_clear      = 1'b1;
                end
`endif
            end
            OFF_HOLD: begin
                if (w_min_off_met) begin
                    if (request) begin
                        w_state_next = ON_HOLD;
                        w_drive_next = 1'b1;
                        w_clear      = 1'b1;
                    end else begin
                        w_state_next = OFF_READY;
                    end
                end
            end
`ifdef DWELL_MAX_ON_EN
            LOCKOUT: begin
                if (!request && w_min_off_met) begin
                    w_state_next = OFF_READY;
                    w_fault_next = 1'b0;
                end
            end
`endif
            default: begin
                w_state_next = OFF_READY;
                w_drive_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= OFF_READY;
            r_drive <= 1'b0;
`ifdef DWELL_MAX_ON_EN
            r_fault <= 1'b0;
`endif
        end else if (clk_enable) begin
            r_state <= w_state_next;
            r_drive <= w_drive_next;
`ifdef DWELL_MAX_ON_EN
            r_fault <= w_fault_next;
`endif
        end
    end

    assign drive   = r_drive;
    assign holding = ((r_state == ON_HOLD) || (r_state == OFF_HOLD)) && (request != r_drive);

`ifdef DWELL_MAX_ON_EN
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_dwell_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_dwell_conditioner
// Brief    : Directed self-checking bench, MIN_ON=3 MIN_OFF=2 MAX_ON=10.
// Revision : 1.0
// ============================================================================
module tb_output_dwell_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    logic request;
    logic drive;
    logic holding;
    logic fault;

    int n_checks = 0;
    int n_pass   = 0;

    output_dwell_conditioner #(
        .WIDTH   (8),
        .MIN_ON  (3),
        .MIN_OFF (2),
        .MAX_ON  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .request    (request),
        .drive      (drive),
        .holding    (holding),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Present inputs, take one clock edge, return 1 time unit after it.
    task automatic apply(input logic req, input logic en);
        request    = req;
        clk_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b1);
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        request    = 1'b1;
        clk_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (drive !== 1'b0) $display("FAIL reset_drive: got %b expected 0", drive);
        else n_pass++;
        n_checks++;
        if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault);
        else n_pass++;
        n_checks++;
        if (holding !== 1'b0) $display("FAIL reset_holding: got %b expected 0", holding);
        else n_pass++;
        reset = 1'b0;
        apply(1'b1, 1'b1);
        n_checks++;
        if (drive !== 1'b1) $display("FAIL reset_first_request: drive got %b expected 1", drive);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        // Entered in ON_HOLD with drive high.
        request = 1'b0;
        #1;
        n_checks++;
        if (holding !== 1'b1) $display("FAIL async_pre_holding: got %b expected 1", holding);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (drive !== 1'b0) $display("FAIL async_reset_drive: got %b expected 0", drive);
        else n_pass++;
        n_checks++;
        if (holding !== 1'b0) $display("FAIL async_reset_holding: got %b expected 0", holding);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle(2);
    endtask

    task automatic test_short_on;
        logic [0:5] req_v  = 6'b100000;
        logic [0:5] drv_v  = 6'b111000;
        logic [0:5] hold_v = 6'b011000;
        int high_ticks = 0;
        for (int i = 0; i < 6; i++) begin
            apply(req_v[i], 1'b1);
            if (drive === 1'b1) high_ticks++;
            n_checks++;
            if (drive !== drv_v[i]) $display("FAIL short_on_drive step %0d: got %b expected %b", i, drive, drv_v[i]);
            else n_pass++;
            n_checks++;
            if (holding !== hold_v[i]) $display("FAIL short_on_holding step %0d: got %b expected %b", i, holding, hold_v[i]);
            else n_pass++;
        end
        n_checks++;
        if (high_ticks != 3) $display("FAIL short_on_width: got %0d ticks expected 3", high_ticks);
        else n_pass++;
    endtask

    task automatic test_short_off_gap;
        logic [0:7] req_v  = 8'b11111011;
        logic [0:7] drv_v  = 8'b11111001;
        logic [0:7] hold_v = 8'b00000010;
        for (int i = 0; i < 8; i++) begin
            apply(req_v[i], 1'b1);
            n_checks++;
            if (drive !== drv_v[i]) $display("FAIL off_gap_drive step %0d: got %b expected %b", i, drive, drv_v[i]);
            else n_pass++;
            n_checks++;
            if (holding !== hold_v[i]) $display("FAIL off_gap_holding step %0d: got %b expected %b", i, holding, hold_v[i]);
            else n_pass++;
        end
        settle(6);
    endtask

    task automatic test_gated_enable;
        int high_clks = 0;
        logic req, en, exp_drv, exp_hold;
        for (int i = 0; i < 24; i++) begin
            en       = ((i % 4) == 0);
            req      = (i < 4) || (i >= 13 && i < 16);
            exp_drv  = (i < 12);
            exp_hold = (i >= 4 && i < 12) || (i >= 13 && i < 16);
            apply(req, en);
            if (drive === 1'b1) high_clks++;
            n_checks++;
            if (drive !== exp_drv) $display("FAIL gated_drive clk %0d: got %b expected %b", i, drive, exp_drv);
            else n_pass++;
            n_checks++;
            if (holding !== exp_hold) $display("FAIL gated_holding clk %0d: got %b expected %b", i, holding, exp_hold);
            else n_pass++;
        end
        n_checks++;
        if (high_clks != 12) $display("FAIL gated_width: got %0d clks expected 12", high_clks);
        else n_pass++;
        clk_enable = 1'b1;
        settle(3);
    endtask

`ifdef DWELL_MAX_ON_EN
    task automatic test_max_on_lockout;
        logic exp_drv, exp_flt;
        for (int i = 0; i < 23; i++) begin
            exp_drv = (i < 10);
            exp_flt = (i >= 10 && i < 20);
            apply(i < 20, 1'b1);
            n_checks++;
            if (drive !== exp_drv) $display("FAIL lockout_drive tick %0d: got %b expected %b", i, drive, exp_drv);
            else n_pass++;
            n_checks++;
            if (fault !== exp_flt) $display("FAIL lockout_fault tick %0d: got %b expected %b", i, fault, exp_flt);
            else n_pass++;
        end
    endtask

    task automatic test_lockout_min_off;
        logic exp_drv, exp_flt;
        for (int i = 0; i < 14; i++) begin
            exp_drv = (i < 10);
            exp_flt = (i == 10) || (i == 11);
            apply(i < 11, 1'b1);
            n_checks++;
            if (drive !== exp_drv) $display("FAIL lockout_minoff_drive tick %0d: got %b expected %b", i, drive, exp_drv);
            else n_pass++;
            n_checks++;
            if (fault !== exp_flt) $display("FAIL lockout_minoff_fault tick %0d: got %b expected %b", i, fault, exp_flt);
            else n_pass++;
        end
    endtask

    task automatic test_max_on_vs_release;
        logic exp_drv;
        for (int i = 0; i < 13; i++) begin
            exp_drv = (i < 10);
            apply(i < 10, 1'b1);
            n_checks++;
            if (drive !== exp_drv) $display("FAIL simult_drive tick %0d: got %b expected %b", i, drive, exp_drv);
            else n_pass++;
            n_checks++;
            if (fault !== 1'b0) $display("FAIL simult_fault tick %0d: got %b expected 0", i, fault);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_lockout;
        repeat (11) apply(1'b1, 1'b1);
        n_checks++;
        if (fault !== 1'b1) $display("FAIL lockout_entry_fault: got %b expected 1", fault);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (fault !== 1'b0) $display("FAIL lockout_reset_fault: got %b expected 0", fault);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle(2);
    endtask
`else
    task automatic test_macro_off;
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 1'b1);
            n_checks++;
            if (drive !== 1'b1) $display("FAIL macro_off_drive tick %0d: got %b expected 1", i, drive);
            else n_pass++;
            n_checks++;
            if (fault !== 1'b0) $display("FAIL macro_off_fault tick %0d: got %b expected 0", i, fault);
            else n_pass++;
        end
        apply(1'b0, 1'b1);
        n_checks++;
        if (drive !== 1'b0) $display("FAIL macro_off_release: drive got %b expected 0", drive);
        else n_pass++;
        settle(3);
    endtask
`endif

    initial begin
        test_reset;
        test_async_reset;
        test_short_on;
        test_short_off_gap;
        test_gated_enable;
`ifdef DWELL_MAX_ON_EN
        test_max_on_lockout;
        test_lockout_min_off;
        test_max_on_vs_release;
        test_reset_in_lockout;
`else
        test_macro_off;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_dwell_conditioner.md
# output_dwell_conditioner

Output-side signal conditioner for actuator drives such as solenoids, relays and injector gates. It turns a raw `request` from software or a control FSM into a `drive` signal that always holds a minimum high time and a minimum low time, and optionally a maximum high time. It sits between synapse peripheral control registers and the board pins. It is the outbound counterpart of the input debouncer: timing is counted in `clk_enable` ticks, not in raw clocks.

## Interface
- `WIDTH`, 8: bit width of the dwell counter.
- `MIN_ON`, 4: minimum high time of `drive`, in enabled ticks (valid range 1 to 2^WIDTH-1).
- `MIN_OFF`, 4: minimum low time of `drive`, in enabled ticks (valid range 1 to 2^WIDTH-1).
- `MAX_ON`, 200: maximum high time, in enabled ticks. Must exceed `MIN_ON`. Used only with `DWELL_MAX_ON_EN`.

- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `clk_enable`, input, 1: tick qualifier. All state advances only on clk edges where this is 1.
- `request`, input, 1: desired drive level, synchronous to `clk`.
- `drive`, output reg, 1: conditioned output to the pin.
- `holding`, output, 1: high while a minimum-dwell hold is overriding `request`.
- `fault`, output reg, 1: max-on lockout is active. Tied to 0 without `DWELL_MAX_ON_EN`.

## Operation
- States:
  - `OFF_HOLD`: drive 0, minimum-off timer running.
  - `OFF_READY`: drive 0, idle.
  - `ON_HOLD`: drive 1, minimum-on timer running.
  - `ON_READY`: drive 1.
  - `LOCKOUT`: drive 0, fault 1.
- Counter `cnt` (WIDTH bits):
  - Cleared to 0 on every state change into `*_HOLD`, `ON_READY` entry excepted.
  - Increments on each enabled tick.
  - Saturates at all-ones; it never wraps.
- Transitions, evaluated only on enabled ticks and using pre-edge values:
  - `OFF_READY` with `request`=1 → `ON_HOLD`, drive←1, cnt←0.
  - `ON_HOLD` with cnt ≥ `MIN_ON`-1 → `ON_READY` if `request`=1. If `request`=0, go to `OFF_HOLD`, drive←0, cnt←0.
  - `ON_READY` with `request`=0 → `OFF_HOLD`, drive←0, cnt←0. `cnt` keeps counting from the `ON_HOLD` entry.
  - `OFF_HOLD` with cnt ≥ `MIN_OFF`-1 → `OFF_READY` if `request`=0. If `request`=1, go to `ON_HOLD`, drive←1, cnt←0.
  - `ON_HOLD` or `ON_READY` with cnt ≥ `MAX_ON`-1 and `request`=1 → `LOCKOUT`, drive←0, fault←1, cnt←0. This applies only with the macro.
  - `LOCKOUT` with `request`=0 and cnt ≥ `MIN_OFF`-1 → `OFF_READY`, fault←0.
- `holding` = (state is `ON_HOLD` or `OFF_HOLD`) AND (`request` ≠ `drive`). It is combinational.
- Net guarantee: the number of enabled edges between consecutive `drive` transitions is at least `MIN_ON` when drive is high and at least `MIN_OFF` when drive is low.
- Request pulses shorter than one enabled tick may be missed. This is by design.

## Timing
- Reset values: state `OFF_READY`, cnt 0, drive 0, fault 0, holding 0. The first request after reset takes effect immediately.
- Latency: `drive` changes on the same clk edge that samples the qualifying `request`. That is one clk after `request` is applied, registered.
- Ticks where `clk_enable`=0 freeze all state. `request` is ignored on those ticks.
- Simultaneous events: if `MAX_ON` expiry and `request`=0 fall on the same tick, the normal `OFF_HOLD` path wins and fault stays 0.
- Reset asserted mid-hold or mid-lockout aborts immediately: drive 0, fault 0, `OFF_READY`.

## Configuration
- `DWELL_MAX_ON_EN` defined:
  - The `MAX_ON` comparison, `LOCKOUT` state and `fault` register are compiled in.
- `DWELL_MAX_ON_EN` not defined:
  - `ON_READY` holds indefinitely.
  - `LOCKOUT` is unreachable and removed.
  - `fault` is constant 0.
  - `MAX_ON` is ignored.

## Structure
- Shared package `dwell_pkg`:
  - State enum `dwell_state_t` (OFF_HOLD, OFF_READY, ON_HOLD, ON_READY, LOCKOUT).
  - Elaboration-time check helpers asserting that MIN_ON and MIN_OFF are ≥1 and fit in WIDTH, and that MAX_ON > MIN_ON.
- Sub-module `dwell_timer`:
  - A saturating WIDTH-bit counter with synchronous clear, count enable (`clk_enable`) and async reset.
  - It exposes `cnt` to the parent FSM comparators.

## Test plan
All cases use MIN_ON=3, MIN_OFF=2, MAX_ON=10, `DWELL_MAX_ON_EN` defined and `clk_enable`=1 every cycle unless noted.
- Reset:
  - Stimulus: hold reset, then release with `request`=1.
  - Required: drive=0 and fault=0 during reset; drive=1 on the first edge after release.
- Short on-request:
  - Stimulus: `request` high for 1 tick, then low.
  - Required: drive high for exactly 3 ticks, `holding`=1 for 2 of them, then drive=0.
- Short off-gap:
  - Stimulus: drive high for 5 ticks, then `request` low for 1 tick, then high.
  - Required: drive low for exactly 2 ticks, then high again.
- Max-on lockout:
  - Stimulus: `request` held high for 20 ticks, then dropped.
  - Required: drive falls on tick 10 and fault=1 until the tick after `request` goes low. Fault clears no earlier than 2 ticks after the lockout started.
- Gated enable:
  - Stimulus: `clk_enable` pulses every 4th clk, 1-tick request.
  - Required: drive high for exactly 12 clks; nothing changes on non-enabled edges.
- Macro off:
  - Stimulus: recompile without `DWELL_MAX_ON_EN`, hold `request` high for 300 ticks.
  - Required: drive stays 1 throughout and fault stays 0.
